// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the data-side memory controller.
package mem_ctrl_pkg;

    // Access size codes as presented by EX; 2'b11 is reserved and behaves as a word.
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUS  = 2'b01,
        MC_DONE = 2'b10
    } mc_state_t;

    // Request attributes held for the life of one bus transfer.
    typedef struct packed {
        logic       wr;
        logic       sign;
        logic [1:0] size;
        logic [1:0] off;
    } mem_req_t;

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering: store replication / byte enables and load extract / extend / rotate.
module mem_lane
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_word,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_sign,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [63:0] ld_dbl;
    logic [31:0] ld_rot;

    assign ld_byte = ld_word[{ld_off, 3'b000} +: 8];
    assign ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    // Rotating a doubled word gives the ARMv4 unaligned-LDR result without a barrel mux.
    assign ld_dbl  = {ld_word, ld_word};
    assign ld_rot  = ld_dbl[{ld_off, 3'b000} +: 32];

    // Store side: replicate the datum across every lane it could land in, enable only its lanes.
    always_comb begin
        st_be   = 4'b1111;
        st_word = st_data;
        case (st_size)
            MEM_SIZE_BYTE: begin
                st_be   = 4'b0001 << st_off;
                st_word = {4{st_data[7:0]}};
            end
            MEM_SIZE_HALF: begin
                st_be   = st_off[1] ? 4'b1100 : 4'b0011;
                st_word = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane and extend it; words (and reserved size) rotate.
    always_comb begin
        ld_data = ld_rot;
        case (ld_size)
            MEM_SIZE_BYTE: ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
            MEM_SIZE_HALF: ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding load/store controller between EX/WB and an ack-handshaked data bus.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_memctrl_vld,
    input  logic        i_memctrl_wr,
    input  logic        i_memctrl_sign,
    input  logic [1:0]  i_memctrl_size,
    input  logic [31:0] i_memctrl_addr,
    input  logic [31:0] i_memctrl_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_vld,
    output logic        o_abort,
    output logic        o_bus_req,
    output logic        o_bus_wr,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic        i_bus_err,
    input  logic [31:0] i_bus_rdata
);

    mc_state_t   state, state_nxt;
    mem_req_t    req_q;
    logic        err_q;
    logic        accept;
    logic        bus_done;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    assign accept   = (state == MC_IDLE) && i_memctrl_vld;
    assign bus_done = (state == MC_BUS) && i_bus_ack;

    // Store formatting works on the live EX request; load formatting on the latched one.
    mem_lane u_lane (
        .st_size (i_memctrl_size),
        .st_off  (i_memctrl_addr[1:0]),
        .st_data (i_memctrl_wdata),
        .st_be   (lane_be),
        .st_word (lane_wdata),
        .ld_size (req_q.size),
        .ld_off  (req_q.off),
        .ld_sign (req_q.sign),
        .ld_word (i_bus_rdata),
        .ld_data (lane_rdata)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= MC_IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs; DONE drops stall so EX retires the request.
    always_comb begin
        state_nxt   = state;
        o_stall     = 1'b0;
        o_bus_req   = 1'b0;
        o_rdata_vld = 1'b0;
        o_abort     = 1'b0;
        case (state)
            MC_IDLE: begin
                if (i_memctrl_vld) begin
                    o_stall   = 1'b1;
                    state_nxt = MC_BUS;
                end
            end
            MC_BUS: begin
                o_stall   = 1'b1;
                o_bus_req = 1'b1;
                if (i_bus_ack) state_nxt = MC_DONE;
            end
            MC_DONE: begin
                state_nxt = MC_IDLE;
                if (err_q)          o_abort     = 1'b1;
                else if (!req_q.wr) o_rdata_vld = 1'b1;
            end
            default: state_nxt = MC_IDLE;
        endcase
    end

    // Latch the request and its bus image at acceptance; bus outputs stay frozen until the next one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_q       <= '0;
            o_bus_wr    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_be    <= '0;
            o_bus_wdata <= '0;
        end else if (accept) begin
            req_q       <= '{wr:   i_memctrl_wr,
                             sign: i_memctrl_sign,
                             size: i_memctrl_size,
                             off:  i_memctrl_addr[1:0]};
            o_bus_wr    <= i_memctrl_wr;
            o_bus_addr  <= {i_memctrl_addr[31:2], 2'b00};
            o_bus_be    <= i_memctrl_wr ? lane_be : 4'b1111;
            o_bus_wdata <= lane_wdata;
        end
    end

    // Capture the formatted read word and error status on the acking cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q   <= 1'b0;
            o_rdata <= '0;
        end else if (bus_done) begin
            err_q   <= i_bus_err;
            o_rdata <= lane_rdata;
        end
    end

endmodule
